// File: rtl/tdm_demux_8_if.sv
// tdm_demux_8_if: TDM slot stream in, recovered eight-channel frame and status out.
interface tdm_demux_8_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               fsync;
  logic [8*WIDTH-1:0] Y;
  logic               frame_valid;
  logic               locked;
  logic               sync_err;
  logic [2:0]         slot;
  modport master (output din, din_valid, fsync, input Y, frame_valid, locked, sync_err, slot);
  modport slave  (input din, din_valid, fsync, output Y, frame_valid, locked, sync_err, slot);
endinterface

// File: rtl/tdm_demux_8.sv
// tdm_demux_8: recovers eight channels from a TDM stream, publishing whole frames only.
module tdm_demux_8 #(parameter int WIDTH = 1) (
  input logic clk,
  input logic rst,
  tdm_demux_8_if.slave bus
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t             r_state, w_state_n;
  logic [2:0]         r_slot, w_slot_n;
  logic [8*WIDTH-1:0] r_shadow, w_shadow_n, r_y, w_y_n;
  logic               r_fv, w_fv_n, r_err, w_err_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= HUNT;
      r_slot   <= '0;
      r_shadow <= '0;
      r_y      <= '0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_slot   <= w_slot_n;
      r_shadow <= w_shadow_n;
      r_y      <= w_y_n;
      r_fv     <= w_fv_n;
      r_err    <= w_err_n;
    end
  // fsync always restarts at slot 0; off slot 0 it also flags an early sync
  always_comb begin
    w_state_n  = r_state;
    w_slot_n   = r_slot;
    w_shadow_n = r_shadow;
    w_y_n      = r_y;
    w_fv_n     = 1'b0;
    w_err_n    = 1'b0;
    if (bus.din_valid) begin
      if (bus.fsync) begin
        w_err_n              = (r_state == LOCKED) && (r_slot != 3'd0);
        w_shadow_n[WIDTH-1:0] = bus.din;
        w_slot_n             = 3'd1;
        w_state_n            = LOCKED;
      end else if (r_state == LOCKED) begin
        if (r_slot == 3'd0) begin
          w_err_n   = 1'b1;
          w_state_n = HUNT;
        end else begin
          w_shadow_n[int'(r_slot)*WIDTH +: WIDTH] = bus.din;
          w_slot_n = r_slot + 3'd1;
          w_fv_n   = (r_slot == 3'd7);
          w_y_n    = (r_slot == 3'd7) ? w_shadow_n : r_y;
        end
      end
    end
  end
  assign bus.Y           = r_y;
  assign bus.frame_valid = r_fv;
  assign bus.sync_err    = r_err;
  assign bus.locked      = (r_state == LOCKED);
  assign bus.slot        = r_slot;
endmodule

// File: doc/tdm_demux_8.md
# tdm_demux_8

Receive-side companion to the 8:1 multiplexer. It recovers eight channels from a time-division-multiplexed stream in which one slot value arrives per accepted beat and eight slots form a frame. Slot k maps to channel k, the same index the transmitter's select lines {S2,S1,S0}=k choose. The block tracks frame alignment, collects a full frame in a shadow register, then presents all eight channels at once with a one-cycle valid pulse.

## Interface
Parameters:
- WIDTH, 1, bits per slot/channel (≥1)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- din  input  WIDTH  slot data
- din_valid  input  1  beat qualifier; din/fsync sampled only when high
- fsync  input  1  marks the beat carrying slot 0; ignored when din_valid low
- Y  output  8*WIDTH  demuxed frame; channel k at Y[k*WIDTH +: WIDTH]
- frame_valid  output  1  one-cycle pulse when Y updates
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on alignment error
- slot  output  3  index of next expected slot (0–7)

## Operation
- Reset values: Y=0, frame_valid=0, locked=0, sync_err=0, slot=0, state=HUNT, shadow=0.
- The block has two states: HUNT and LOCKED.
- HUNT:
  - Beats without fsync are discarded.
  - A beat with fsync=1 stores din in shadow slot 0, sets slot=1 and moves to LOCKED.
- LOCKED: each accepted beat stores din into shadow[slot], then increments slot mod 8.
  - Beat at slot 7 (no fsync): frame complete. Y ← shadow with the slot-7 value merged. frame_valid pulses. slot=0.
  - Beat at slot 0 with fsync=1: normal start of a frame.
  - Beat at slot 0 with fsync=0 (missing sync): sync_err pulses, the beat is discarded, state goes to HUNT, slot=0.
  - Beat at slot 1–7 with fsync=1 (early sync): sync_err pulses and the partial frame is abandoned. Y is not updated. This beat becomes slot 0 of a new frame (slot=1) and the block stays LOCKED.
- Y holds its value between completed frames and never shows a partial frame.
- fsync on a beat at slot 7 counts as early sync, not completion.
- din_valid low: no state, slot or shadow change. Gaps of any length are allowed mid-frame.

## Timing
- Outputs are registered.
- Y and frame_valid change on the clock edge that samples the slot-7 beat. They are visible the following cycle, so latency from the slot-7 beat is 1 cycle.
- Back-to-back frames are allowed: the slot-0 beat of the next frame may directly follow the slot-7 beat, giving a maximum throughput of 1 frame per 8 cycles.
- sync_err is asserted in the cycle after the offending beat.
- locked drops in the same cycle that sync_err asserts for a missing sync.
- locked rises the cycle after the fsync beat accepted in HUNT.
- frame_valid and sync_err are never high together.
- Asserting rst at any time, including mid-frame, returns all outputs to their reset values immediately, without waiting for a clock edge. The first frame after reset needs a new fsync.

## Test plan
- Reset: assert rst mid-sim with no clock edge → Y=0, frame_valid=0, locked=0, slot=0 within the same timestep.
- Clean frame, WIDTH=1:
  - Stimulus: fsync with bit0, then bits of 8'b01100011 for slots 0..7, din_valid continuous.
  - Response: one cycle after the slot-7 beat, Y=8'h63, frame_valid high for exactly 1 cycle, locked=1.
- Gapped beats:
  - Stimulus: same frame with din_valid low for 3 cycles between slots 2 and 3, and 1 cycle between 5 and 6.
  - Response: Y=8'h63, frame_valid pulses once, and slot holds during gaps.
- Early fsync:
  - Stimulus: after Y=8'h63, send slots 0–3 of 8'hFF, then fsync with a full frame 8'hA5.
  - Response: sync_err pulses once after the fsync beat. Y stays 8'h63 until the A5 frame completes, then Y=8'hA5.
- Missing fsync:
  - Stimulus: after a complete frame, the next beat has fsync=0.
  - Response: sync_err pulses and locked=0. Further non-fsync beats leave Y unchanged. A later fsync frame of 8'h3C gives Y=8'h3C.
- WIDTH=4 back-to-back:
  - Stimulus: frames with slot k=k+1, then slot k=15−k, no gaps.
  - Response: Y=32'h87654321, then Y=32'h89ABCDEF, with frame_valid pulses exactly 8 cycles apart.
